// File: rtl/draw_datapath.sv
// draw_datapath: executes controller commands, updates bird/wall geometry, streams pixels to the VGA adapter
module draw_datapath #(
  parameter int unsigned BIRD_X    = 20,
  parameter int unsigned BIRD_SIZE = 4,
  parameter int unsigned WALL_W    = 8,
  parameter int unsigned GAP_H     = 32,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       flag,
  output logic       collision,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [6:0] BIRD_MAX = 7'(SCREEN_H - BIRD_SIZE);
  state_t state, state_n;
  logic [3:0] cmd_q, acmd;
  logic [6:0] bird_y, gap_y, cy, ny, y0, h, py;
  logic [7:0] wall_x, lfsr, lfsr_n, cx, nx, x0, w, px;
  logic [2:0] col;
  logic accept, bird, wall, is_scan, last, emit, pix_on, ox, hit, eval;
  assign cmd_ready = state == IDLE || state == DONE;
  assign flag = state == DONE;
  assign accept = cmd_valid && cmd_ready;
  assign lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign ox = 9'(BIRD_X + BIRD_SIZE - 1) >= {1'b0, wall_x} && 9'(BIRD_X) <= {1'b0, wall_x} + 9'(WALL_W - 1);
  assign hit = (ox && ({2'b0, bird_y} < {2'b0, gap_y} ||
               {2'b0, bird_y} + 9'(BIRD_SIZE - 1) >= {2'b0, gap_y} + 9'(GAP_H))) || bird_y == BIRD_MAX;
  assign eval = state == DONE && (cmd_q == 4'd2 || cmd_q == 4'd3 || cmd_q == 4'd6);
  // scan geometry of the active command and the next pixel it emits
  always_comb begin
    acmd = accept ? cmd : cmd_q;
    bird = acmd == 4'd1 || acmd == 4'd4;
    wall = acmd == 4'd5 || acmd == 4'd7;
    is_scan = bird || wall || acmd == 4'd8;
    x0 = bird ? 8'(BIRD_X) : wall ? wall_x : 8'd0;
    y0 = bird ? bird_y : 7'd0;
    w = bird ? 8'(BIRD_SIZE) : wall ? 8'(WALL_W) : 8'(SCREEN_W);
    h = bird ? 7'(BIRD_SIZE) : 7'(SCREEN_H);
    col = acmd == 4'd4 ? 3'b110 : acmd == 4'd7 ? 3'b010 : 3'b000;
    last = cx == w - 8'd1 && cy == h - 7'd1;
    nx = accept || cx == w - 8'd1 ? 8'd0 : cx + 8'd1;
    ny = accept ? 7'd0 : cx == w - 8'd1 ? cy + 7'd1 : cy;
    px = x0 + nx;
    py = y0 + ny;
    pix_on = !wall || {2'b0, py} < {2'b0, gap_y} || {2'b0, py} >= {2'b0, gap_y} + 9'(GAP_H);
    emit = accept ? is_scan : state == SCAN && !last;
    state_n = accept ? (is_scan ? SCAN : DONE) :
              state == SCAN ? (last ? DONE : SCAN) : IDLE;
  end
  // state, geometry, collision and registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_q <= 4'd0;
      bird_y <= 7'd56;
      wall_x <= 8'd152;
      gap_y <= 7'd40;
      lfsr <= 8'hA5;
      collision <= 1'b0;
      cx <= 8'd0;
      cy <= 7'd0;
      x <= 8'd0;
      y <= 7'd0;
      colour <= 3'd0;
      plot <= 1'b0;
    end else begin
      state <= state_n;
      plot <= emit && pix_on;
      if (emit) begin
        cx <= nx;
        cy <= ny;
        colour <= col;
      end
      if (emit && pix_on) begin
        x <= px;
        y <= py;
      end
      if (eval) collision <= collision | hit;
      if (accept) begin
        cmd_q <= cmd;
        if (cmd == 4'd2) bird_y <= bird_y < 7'd2 ? 7'd0 : bird_y - 7'd2;
        if (cmd == 4'd3) bird_y <= bird_y >= BIRD_MAX ? BIRD_MAX : bird_y + 7'd1;
        if (cmd == 4'd6) begin
          wall_x <= wall_x == 8'd0 ? 8'(SCREEN_W - WALL_W) : wall_x - 8'd1;
          if (wall_x == 8'd0) begin
            lfsr <= lfsr_n;
            gap_y <= 7'd16 + {1'b0, lfsr_n[5:0]};
          end
        end
        if (cmd == 4'd8) collision <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_draw_datapath.sv
// tb_draw_datapath: directed vector table plus hand sequences for draw_datapath
module tb_draw_datapath;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic cmd_ready, flag, collision, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  int n_cmp = 0, n_err = 0;
  int lat, np, fx, fy, lx, ly, fcol, gap_n, rdy1, rdy_flag, col_flag;
  int gap_lo = 40, gap_hi = 72;
  typedef struct {
    logic [3:0] c;
    int lat, np, fx, fy, lx, ly, col;
  } vec_t;
  vec_t tv[10];

  draw_datapath dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .flag(flag), .collision(collision), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] c);
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    np = 0; gap_n = 0; fx = -1; fy = -1; lx = -1; ly = -1; fcol = -1; lat = -1;
    rdy1 = cmd_ready;
    for (int k = 1; k <= 20000; k++) begin
      if (plot) begin
        if (np == 0) begin fx = x; fy = y; fcol = colour; end
        lx = x; ly = y; np++;
        if (y >= gap_lo && y < gap_hi) gap_n++;
      end
      if (flag) begin
        lat = k; rdy_flag = cmd_ready; col_flag = collision;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0) chk("flag_timeout", 0, 1);
  endtask

  task automatic do_reset(input string t);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk({t, "_ready"}, cmd_ready, 1);
    chk({t, "_flag"}, flag, 0);
    chk({t, "_coll"}, collision, 0);
    chk({t, "_plot"}, plot, 0);
    chk({t, "_x"}, x, 0);
    chk({t, "_y"}, y, 0);
    chk({t, "_colour"}, colour, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic after_flag(input string t, input int exp);
    @(posedge clk);
    #1;
    chk(t, collision, exp);
  endtask

  initial begin
    tv[0] = '{4'd4, 17, 16, 20, 56, 23, 59, 6};
    tv[1] = '{4'd1, 17, 16, 20, 56, 23, 59, 0};
    tv[2] = '{4'd0, 1, 0, 0, 0, 0, 0, 0};
    tv[3] = '{4'd2, 1, 0, 0, 0, 0, 0, 0};
    tv[4] = '{4'd4, 17, 16, 20, 54, 23, 57, 6};
    tv[5] = '{4'd3, 1, 0, 0, 0, 0, 0, 0};
    tv[6] = '{4'd15, 1, 0, 0, 0, 0, 0, 0};
    tv[7] = '{4'd6, 1, 0, 0, 0, 0, 0, 0};
    tv[8] = '{4'd7, 961, 704, 151, 0, 158, 119, 2};
    tv[9] = '{4'd5, 961, 704, 151, 0, 158, 119, 0};
    repeat (2) @(posedge clk);
    do_reset("rst0");
    for (int i = 0; i < 10; i++) begin
      run_cmd(tv[i].c);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_plots", i), np, tv[i].np);
      chk($sformatf("v%0d_rdy1", i), rdy1, int'(tv[i].lat == 1));
      chk($sformatf("v%0d_rdyflag", i), rdy_flag, 1);
      if (tv[i].np > 0) begin
        chk($sformatf("v%0d_fx", i), fx, tv[i].fx);
        chk($sformatf("v%0d_fy", i), fy, tv[i].fy);
        chk($sformatf("v%0d_lx", i), lx, tv[i].lx);
        chk($sformatf("v%0d_ly", i), ly, tv[i].ly);
        chk($sformatf("v%0d_col", i), fcol, tv[i].col);
      end
      if (tv[i].c == 4'd5 || tv[i].c == 4'd7) chk($sformatf("v%0d_gap", i), gap_n, 0);
    end
    after_flag("tbl_coll", 0);
    // bird saturation at top and bottom, bottom hit
    repeat (28) run_cmd(4'd2);
    run_cmd(4'd3);
    run_cmd(4'd2);
    run_cmd(4'd4);
    chk("top_sat_y", fy, 0);
    repeat (115) run_cmd(4'd3);
    chk("y115_coll", col_flag, 0);
    run_cmd(4'd3);
    chk("ground_coll_flagcyc", col_flag, 0);
    after_flag("ground_coll", 1);
    repeat (4) run_cmd(4'd3);
    run_cmd(4'd4);
    chk("bot_sat_fy", fy, 116);
    chk("bot_sat_ly", ly, 119);
    chk("coll_sticky", collision, 1);
    // wall wrap, lfsr step, new gap
    do_reset("rst1");
    repeat (152) run_cmd(4'd6);
    run_cmd(4'd6);
    chk("wrap_coll", col_flag, 0);
    gap_lo = 26; gap_hi = 58;
    run_cmd(4'd7);
    chk("wrap_lat", lat, 961);
    chk("wrap_plots", np, 704);
    chk("wrap_fx", fx, 152);
    chk("wrap_lx", lx, 159);
    chk("wrap_gap26", gap_n, 0);
    gap_lo = 40; gap_hi = 72;
    // wall hits bird above the gap, then CLEAR
    do_reset("rst2");
    repeat (13) run_cmd(4'd2);
    repeat (128) run_cmd(4'd6);
    after_flag("wall24_coll", 0);
    run_cmd(4'd6);
    chk("wall23_coll_flagcyc", col_flag, 0);
    after_flag("wall23_coll", 1);
    repeat (4) run_cmd(4'd6);
    chk("wall19_coll", col_flag, 1);
    run_cmd(4'd8);
    chk("clr_lat", lat, 19201);
    chk("clr_plots", np, 19200);
    chk("clr_fx", fx, 0);
    chk("clr_fy", fy, 0);
    chk("clr_lx", lx, 159);
    chk("clr_ly", ly, 119);
    after_flag("clr_coll", 0);
    // cmd_valid held during a wall scan; command taken in the flag cycle
    begin
      int bad = 0, fk = -1;
      @(negedge clk);
      cmd = 4'd7;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd = 4'd1;
      np = 0;
      for (int k = 1; k <= 1000; k++) begin
        if (plot) begin np++; if (colour != 3'b010) bad++; end
        if (flag) begin fk = k; break; end
        @(posedge clk);
        #1;
      end
      chk("busy_lat", fk, 961);
      chk("busy_plots", np, 704);
      chk("busy_colour", bad, 0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("b2b_plot", plot, 1);
      chk("b2b_x", x, 20);
      chk("b2b_y", y, 30);
      chk("b2b_ready", cmd_ready, 0);
      np = 0; fk = -1;
      for (int k = 962; k <= 1100; k++) begin
        if (plot) np++;
        if (flag) begin fk = k; break; end
        @(posedge clk);
        #1;
      end
      chk("b2b_plots", np, 16);
      chk("b2b_flag", fk, 978);
    end
    // reset in the middle of a CLEAR scan
    begin
      int nf = 0;
      @(negedge clk);
      cmd = 4'd8;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (99) begin @(posedge clk); #1; end
      chk("mid_plot100", plot, 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_plot", plot, 0);
      chk("mid_ready", cmd_ready, 1);
      chk("mid_flag", flag, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (flag || plot) nf++; end
      chk("mid_quiet", nf, 0);
      run_cmd(4'd0);
      chk("mid_nop_lat", lat, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
